linear_issue_scheduler: RTL
===========================

LINEAR_ISSUE_SCHEDULER -- requirements
Module: linear_issue_scheduler

Interface
REQ-001 Parameter N_ICFG, default 4: number of index slots per range.
REQ-002 Parameter MAX_OUTST, default 2: maximum issued-but-uncredited indices, range 1..7.
REQ-003 Localparam ICFG_BW = $clog2(N_ICFG+1); CBW = $clog2(MAX_OUTST+1).
REQ-004 i_clk  in  1  clock, rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-low.
REQ-006 range_rdy  in  1  range command valid.
REQ-007 range_ack  out  1  range command accepted.
REQ-008 i_beg  in  ICFG_BW  first index, inclusive.
REQ-009 i_end  in  ICFG_BW  end index, exclusive.
REQ-010 idx_rdy  out  1  index request valid to the address generator.
REQ-011 idx_ack  in  1  index request accepted.
REQ-012 o_idx  out  ICFG_BW  current index.
REQ-013 o_last  out  1  o_idx is the final index of the range.
REQ-014 i_credit  in  1  one-cycle pulse: one issued index fully collected, one credit returned.
REQ-015 o_busy  out  1  high in any state other than IDLE.
REQ-016 o_err  out  1  sticky error: credit overflow.
REQ-017 o_stall_cnt  out  16  stall counter; present only with the macro in REQ-035.

Function
REQ-018 Handshake: a transfer occurs on a cycle with rdy and ack both high; the producer holds rdy and data stable until that cycle.
REQ-019 FSM states: IDLE, ISSUE, DRAIN.
REQ-020 IDLE: range_ack = range_rdy. On the accept cycle, cur_idx <= i_beg and end_r <= i_end.
REQ-021 IDLE transitions on accept: i_beg == i_end (empty range) -> stay in IDLE and issue nothing; i_beg > i_end is treated as empty; otherwise -> ISSUE.
REQ-022 In ISSUE and DRAIN, range_ack = 0.
REQ-023 ISSUE outputs: idx_rdy = (credits != 0); o_idx = cur_idx; o_last = (cur_idx + 1 == end_r), computed at ICFG_BW+1 width with no wrap.
REQ-024 ISSUE on idx_ack: credits decrement; cur_idx increments; if o_last, go to DRAIN.
REQ-025 DRAIN: idx_rdy = 0; go to IDLE on the cycle credits become MAX_OUTST, registered so that o_busy falls the following cycle.
REQ-026 Credits reset to MAX_OUTST. A cycle with both idx_ack and i_credit leaves credits unchanged.
REQ-027 i_credit while credits == MAX_OUTST (and no simultaneous idx_ack): credits stay saturated and o_err sets.
REQ-028 Latency: first idx_rdy is asserted the cycle after range accept; back-to-back issue of one index per cycle while credits > 0.
REQ-029 o_idx, o_last and end_r are registered or decoded from registers only; no combinational path from range_rdy to idx_rdy.
REQ-030 idx_ack while idx_rdy is low is ignored.

Reset
REQ-031 Asynchronous assert on i_rst low: state = IDLE, cur_idx = 0, end_r = 0, credits = MAX_OUTST, o_err = 0, o_stall_cnt = 0.
REQ-032 Reset outputs: idx_rdy = 0, range_ack = 0, o_last = 0, o_busy = 0.
REQ-033 Reset mid-range aborts the range; pending credits are discarded and no idx_rdy is asserted until a new range is accepted.
REQ-034 Reset release is synchronous to i_clk through the codebase reset synchronizer; the block assumes a synchronized deassert.

Configuration
REQ-035 Macro LINEAR_SCHED_PERF_EN. When defined, o_stall_cnt increments, saturating at 16'hFFFF, on each ISSUE cycle with credits == 0, and resets only on i_rst.
REQ-036 When LINEAR_SCHED_PERF_EN is undefined, the o_stall_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-037 MAX_OUTST=2, range beg=1 end=4, idx_ack always high, i_credit 2 cycles after each ack -> o_idx 1,2,3 issued, o_last only on 3, DRAIN, o_busy low after the third credit.
REQ-038 beg=2 end=2 -> range_ack in 1 cycle, idx_rdy never high, o_busy stays 0.
REQ-039 MAX_OUTST=2, beg=0 end=4, no i_credit -> idx_rdy drops after 2 acks; with LINEAR_SCHED_PERF_EN, o_stall_cnt increments each held cycle; one credit releases idx 2.
REQ-040 idx_ack and i_credit in the same cycle with credits=1 -> credits stay 1, issue continues without a bubble.
REQ-041 i_credit pulse in IDLE with credits=MAX_OUTST -> o_err=1 and stays 1 until reset.
REQ-042 i_rst asserted low after the second issue of a 4-index range -> next cycle idx_rdy=0, o_busy=0, credits=MAX_OUTST; a new range then issues from its i_beg.

Source files
------------

// File: rtl/linear_issue_scheduler.sv
// Issues indices i_beg..i_end-1 one per cycle, limited to MAX_OUTST uncollected indices.
// Define LINEAR_SCHED_PERF_EN to add the o_stall_cnt credit-starvation counter.
module linear_issue_scheduler #(
  parameter int N_ICFG    = 4,
  parameter int MAX_OUTST = 2,
  localparam int ICFG_BW  = $clog2(N_ICFG + 1),
  localparam int CBW      = $clog2(MAX_OUTST + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               range_rdy,
  output logic               range_ack,
  input  logic [ICFG_BW-1:0] i_beg,
  input  logic [ICFG_BW-1:0] i_end,
  output logic               idx_rdy,
  input  logic               idx_ack,
  output logic [ICFG_BW-1:0] o_idx,
  output logic               o_last,
  input  logic               i_credit,
  output logic               o_busy,
  output logic               o_err
`ifdef LINEAR_SCHED_PERF_EN
  ,
  output logic [15:0]        o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CBW-1:0] CRED_MAX = CBW'(MAX_OUTST);

  state_t             state_q, state_d;
  logic [ICFG_BW-1:0] cur_idx_q, cur_idx_d;
  logic [ICFG_BW-1:0] end_q, end_d;
  logic [CBW-1:0]     credits_q, credits_d;
  logic               err_q, err_d;
  logic               issue_s;
  logic               last_s;
`ifdef LINEAR_SCHED_PERF_EN
  logic [15:0]        stall_cnt_q, stall_cnt_d;
`endif

  // One bit wider so an end index at the top of the range cannot wrap.
  assign last_s    = (({1'b0, cur_idx_q} + {{ICFG_BW{1'b0}}, 1'b1}) == {1'b0, end_q});
  assign range_ack = i_rst & (state_q == IDLE) & range_rdy;
  assign idx_rdy   = (state_q == ISSUE) & (credits_q != {CBW{1'b0}});
  assign issue_s   = idx_rdy & idx_ack;
  assign o_idx     = cur_idx_q;
  assign o_last    = (state_q == ISSUE) & last_s;
  assign o_busy    = (state_q != IDLE);
  assign o_err     = err_q;
`ifdef LINEAR_SCHED_PERF_EN
  assign o_stall_cnt = stall_cnt_q;
`endif

  // Credit pool: issue spends one, collection returns one, both together cancel.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (issue_s && !i_credit) begin
      credits_d = credits_q - CBW'(1);
    end else if (!issue_s && i_credit) begin
      if (credits_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CBW'(1);
      end
    end else begin
      credits_d = credits_q;
    end
  end

  // Range walk state machine.
  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    end_d     = end_q;
    case (state_q)
      IDLE: begin
        if (range_rdy) begin
          cur_idx_d = i_beg;
          end_d     = i_end;
          state_d   = (i_beg < i_end) ? ISSUE : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (issue_s) begin
          cur_idx_d = cur_idx_q + ICFG_BW'(1);
          state_d   = last_s ? DRAIN : ISSUE;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        state_d = (credits_d == CRED_MAX) ? IDLE : DRAIN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef LINEAR_SCHED_PERF_EN
  // Counts cycles where an index is pending but no credit is available.
  always_comb begin
    if ((state_q == ISSUE) && (credits_q == {CBW{1'b0}}) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end
`endif

  // State registers; reset aborts any range and restores the full credit pool.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      cur_idx_q   <= {ICFG_BW{1'b0}};
      end_q       <= {ICFG_BW{1'b0}};
      credits_q   <= CRED_MAX;
      err_q       <= 1'b0;
`ifdef LINEAR_SCHED_PERF_EN
      stall_cnt_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      cur_idx_q   <= cur_idx_d;
      end_q       <= end_d;
      credits_q   <= credits_d;
      err_q       <= err_d;
`ifdef LINEAR_SCHED_PERF_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

endmodule
